// File: rtl/pipeif.sv
// Instruction-fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Branch-delay-slot machine, so the instruction after a redirect is never flushed.
module pipeif #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid,
    output logic [31:0] fcount,
    output logic        pcerr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc4_q, inst_q, fcount_q;
    logic        dvalid_q, pcerr_q;
    logic [31:0] pc4, npc;
    logic        misaligned_jr;

    always_comb begin
        pc4 = pc_q + 32'd4;
        npc = pc4;
        case (pcsource)
            2'b01:   npc = bpc;
            2'b10:   npc = da;
            2'b11:   npc = jpc;
            default: npc = pc4;
        endcase
        // Fetch addresses are word aligned; low bits of any target are dropped.
        pc_d = npc & 32'hFFFF_FFFC;
    end

    assign misaligned_jr = (pcsource == 2'b10) && (da[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            dpc4_q   <= 32'd0;
            inst_q   <= 32'h0000_0000;
            dvalid_q <= 1'b0;
            fcount_q <= 32'd0;
            pcerr_q  <= 1'b0;
        end else if (wpcir) begin
            pc_q     <= pc_d;
            dpc4_q   <= pc4;
            inst_q   <= imem_data;
            dvalid_q <= 1'b1;
            fcount_q <= fcount_q + 32'd1;
            pcerr_q  <= pcerr_q | misaligned_jr;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dpc4      = dpc4_q;
    assign inst      = inst_q;
    assign dvalid    = dvalid_q;
    assign fcount    = fcount_q;
    assign pcerr     = pcerr_q;

endmodule

// File: tb/tb_pipeif.sv
// Self-checking bench for pipeif: directed scenarios plus a randomized run
// checked against a behavioural model of the fetch stage.
module tb_pipeif;

    logic        clock, reset, wpcir, rom_mode;
    logic [1:0]  pcsource;
    logic [31:0] bpc, da, jpc, imem_data, imem_addr, pc, dpc4, inst, fcount;
    logic        dvalid, pcerr;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the architectural state.
    logic [31:0] m_pc, m_dpc4, m_inst, m_fcount;
    logic        m_dvalid, m_pcerr;

    pipeif dut (
        .clock     (clock),
        .reset     (reset),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .da        (da),
        .jpc       (jpc),
        .wpcir     (wpcir),
        .imem_data (imem_data),
        .imem_addr (imem_addr),
        .pc        (pc),
        .dpc4      (dpc4),
        .inst      (inst),
        .dvalid    (dvalid),
        .fcount    (fcount),
        .pcerr     (pcerr)
    );

    function automatic logic [31:0] rom(input logic [31:0] a, input logic mode);
        if (mode) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        return 32'h1000_0000 + a;
    endfunction

    assign imem_data = rom(imem_addr, rom_mode);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle's inputs, advance the model, then move 1 time unit past the edge.
    task automatic step(input logic [1:0] ps, input logic [31:0] b, input logic [31:0] d,
                        input logic [31:0] j, input logic w, input logic r);
        logic [31:0] target;
        pcsource = ps; bpc = b; da = d; jpc = j; wpcir = w; reset = r;
        if (r) begin
            m_pc = 32'h0; m_dpc4 = 32'h0; m_inst = 32'h0;
            m_dvalid = 1'b0; m_fcount = 32'h0; m_pcerr = 1'b0;
        end else if (w) begin
            if (ps == 2'd0)      target = m_pc + 32'd4;
            else if (ps == 2'd1) target = b;
            else if (ps == 2'd2) target = d;
            else                 target = j;
            if (ps == 2'd2 && (d % 4) != 0) m_pcerr = 1'b1;
            m_dpc4   = m_pc + 32'd4;
            m_inst   = rom(m_pc, rom_mode);
            m_pc     = target - (target % 4);
            m_dvalid = 1'b1;
            m_fcount = m_fcount + 32'd1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests += 6;
        if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc); end
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h exp 0", inst); end
        if (dvalid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid got %b exp 0", dvalid); end
        if (fcount !== 32'h0) begin n_fail++; $display("FAIL reset_fcount got %h exp 0", fcount); end
        if (pcerr !== 1'b0) begin n_fail++; $display("FAIL reset_pcerr got %b exp 0", pcerr); end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_tests++;
            if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_pc[i]); end
            if (i == 1) begin
                n_tests += 3;
                if (inst !== 32'h1000_0004) begin n_fail++; $display("FAIL seq_inst got %h exp 10000004", inst); end
                if (dpc4 !== 32'h8) begin n_fail++; $display("FAIL seq_dpc4 got %h exp 8", dpc4); end
                if (dvalid !== 1'b1) begin n_fail++; $display("FAIL seq_dvalid got %b exp 1", dvalid); end
            end
        end
        n_tests++;
        if (fcount !== 32'd4) begin n_fail++; $display("FAIL seq_fcount got %0d exp 4", fcount); end
    endtask

    task automatic test_branch;
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'd1, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests += 3;
        if (pc !== 32'h40) begin n_fail++; $display("FAIL br_pc got %h exp 40", pc); end
        if (dpc4 !== 32'hC) begin n_fail++; $display("FAIL br_dpc4 got %h exp c", dpc4); end
        if (inst !== 32'h1000_0008) begin n_fail++; $display("FAIL br_slot_inst got %h exp 10000008", inst); end
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests += 2;
        if (inst !== 32'h1000_0040) begin n_fail++; $display("FAIL br_target_inst got %h exp 10000040", inst); end
        if (pc !== 32'h44) begin n_fail++; $display("FAIL br_next_pc got %h exp 44", pc); end
    endtask

    task automatic test_jumps;
        step(2'd3, 32'h0, 32'h0, 32'h0040_0100, 1'b1, 1'b0);
        n_tests += 2;
        if (pc !== 32'h0040_0100) begin n_fail++; $display("FAIL j_pc got %h exp 00400100", pc); end
        if (pcerr !== 1'b0) begin n_fail++; $display("FAIL j_pcerr got %b exp 0", pcerr); end
        step(2'd2, 32'h0, 32'h0000_0203, 32'h0, 1'b1, 1'b0);
        n_tests += 2;
        if (pc !== 32'h200) begin n_fail++; $display("FAIL jr_pc got %h exp 200", pc); end
        if (pcerr !== 1'b1) begin n_fail++; $display("FAIL jr_pcerr got %b exp 1", pcerr); end
        for (int i = 0; i < 10; i++) begin
            step(2'd0, 32'h0, 32'h0, 32'h0, 1'(i % 2), 1'b0);
            n_tests++;
            if (pcerr !== 1'b1) begin n_fail++; $display("FAIL pcerr_sticky[%0d] got %b exp 1", i, pcerr); end
        end
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (pcerr !== 1'b0) begin n_fail++; $display("FAIL pcerr_clear got %b exp 0", pcerr); end
    endtask

    task automatic test_stall;
        logic [31:0] h_pc, h_inst, h_dpc4, h_fc;
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        h_pc = m_pc; h_inst = m_inst; h_dpc4 = m_dpc4; h_fc = m_fcount;
        for (int i = 0; i < 3; i++) begin
            step(2'd1, 32'h80, 32'h0, 32'h0, 1'b0, 1'b0);
            n_tests += 4;
            if (pc !== h_pc) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp %h", i, pc, h_pc); end
            if (inst !== h_inst) begin n_fail++; $display("FAIL stall_inst[%0d] got %h exp %h", i, inst, h_inst); end
            if (dpc4 !== h_dpc4) begin n_fail++; $display("FAIL stall_dpc4[%0d] got %h exp %h", i, dpc4, h_dpc4); end
            if (fcount !== h_fc) begin n_fail++; $display("FAIL stall_fcount[%0d] got %0d exp %0d", i, fcount, h_fc); end
        end
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (pc !== h_pc + 32'd4) begin n_fail++; $display("FAIL stall_release_pc got %h exp %h", pc, h_pc + 32'd4); end
    endtask

    task automatic test_wrap;
        step(2'd2, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_load got %h exp fffffffc", pc); end
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_tests += 2;
        if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", pc); end
        if (dpc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_dpc4 got %h exp 0", dpc4); end
    endtask

    task automatic test_reset_priority;
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(2'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'd1, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0);
        step(2'd2, 32'h0, 32'h7, 32'h0, 1'b0, 1'b0);
        n_tests += 2;
        if (pc !== 32'h40) begin n_fail++; $display("FAIL rp_setup_pc got %h exp 40", pc); end
        if (fcount !== 32'd9) begin n_fail++; $display("FAIL rp_setup_fcount got %0d exp 9", fcount); end
        step(2'd2, 32'h0, 32'h3, 32'h0, 1'b1, 1'b1);
        n_tests += 5;
        if (pc !== 32'h0) begin n_fail++; $display("FAIL rp_pc got %h exp 0", pc); end
        if (inst !== 32'h0) begin n_fail++; $display("FAIL rp_inst got %h exp 0", inst); end
        if (dvalid !== 1'b0) begin n_fail++; $display("FAIL rp_dvalid got %b exp 0", dvalid); end
        if (fcount !== 32'h0) begin n_fail++; $display("FAIL rp_fcount got %0d exp 0", fcount); end
        if (pcerr !== 1'b0) begin n_fail++; $display("FAIL rp_pcerr got %b exp 0", pcerr); end
    endtask

    task automatic test_random;
        logic [31:0] rb, rd, rj;
        rom_mode = 1'b1;
        step(2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            rb = $urandom; rd = $urandom; rj = $urandom;
            if ($urandom_range(0, 3) != 0) rd = rd & 32'hFFFF_FFFC;
            step(2'($urandom_range(0, 3)), rb, rd, rj, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0));
            n_tests += 7;
            if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, pc, m_pc); end
            if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, imem_addr, m_pc); end
            if (dpc4 !== m_dpc4) begin n_fail++; $display("FAIL rnd_dpc4[%0d] got %h exp %h", i, dpc4, m_dpc4); end
            if (inst !== m_inst) begin n_fail++; $display("FAIL rnd_inst[%0d] got %h exp %h", i, inst, m_inst); end
            if (dvalid !== m_dvalid) begin n_fail++; $display("FAIL rnd_dvalid[%0d] got %b exp %b", i, dvalid, m_dvalid); end
            if (fcount !== m_fcount) begin n_fail++; $display("FAIL rnd_fcount[%0d] got %0d exp %0d", i, fcount, m_fcount); end
            if (pcerr !== m_pcerr) begin n_fail++; $display("FAIL rnd_pcerr[%0d] got %b exp %b", i, pcerr, m_pcerr); end
        end
        rom_mode = 1'b0;
    endtask

    initial begin
        rom_mode = 1'b0;
        reset = 1'b1; wpcir = 1'b0; pcsource = 2'd0; bpc = '0; da = '0; jpc = '0;
        m_pc = '0; m_dpc4 = '0; m_inst = '0; m_fcount = '0; m_dvalid = 1'b0; m_pcerr = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jumps();
        test_stall();
        test_wrap();
        test_reset_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
